button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, number of consecutive clocks a new level must hold before it is accepted (10 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter: LONG_PRESS_CYCLES, default 100000000, number of clocks in the HELD state before a long press is reported (2 s at 50 MHz); legal range >= DEBOUNCE_CYCLES.
REQ-003 Parameter: ACTIVE_LOW, default 1, meaning btn_raw=0 is pressed when 1 and btn_raw=1 is pressed when 0.
REQ-004 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_raw  input  1  raw push-button pin, asynchronous to clk, bouncing.
REQ-007 btn_level  output  1  debounced level, 1 = pressed.
REQ-008 press_pulse  output  1  one-clock pulse on each accepted press; drives a toggle/go input downstream.
REQ-009 release_pulse  output  1  one-clock pulse on each accepted release.
REQ-010 long_press_pulse  output  1  one-clock pulse when a press has been held LONG_PRESS_CYCLES.

Function
REQ-011 The block SHALL pass btn_raw through a 2-flop synchronizer, then normalize polarity per ACTIVE_LOW, giving s (1 = pressed).
REQ-012 The FSM SHALL have four states: IDLE, DB_PRESS, HELD and DB_RELEASE; one debounce counter db_cnt and one hold counter hold_cnt, each sized by $clog2 of its limit.
REQ-013 IDLE: s=1 -> DB_PRESS with db_cnt=0; s=0 -> stay.
REQ-014 DB_PRESS: s=0 -> IDLE with no pulse (bounce rejected); s=1 and db_cnt<DEBOUNCE_CYCLES-1 -> db_cnt+1; s=1 and db_cnt==DEBOUNCE_CYCLES-1 -> HELD, hold_cnt=0, press_pulse=1 next cycle.
REQ-015 HELD: s=0 -> DB_RELEASE with db_cnt=0; hold_cnt increments each cycle in HELD and saturates at LONG_PRESS_CYCLES-1.
REQ-016 long_press_pulse SHALL be high for exactly one cycle, on the cycle after hold_cnt reaches LONG_PRESS_CYCLES-1; it fires at most once per accepted press.
REQ-017 DB_RELEASE: s=1 -> HELD with hold_cnt preserved (bounce rejected, no pulse); s=0 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 next cycle; otherwise db_cnt+1.
REQ-018 hold_cnt SHALL hold its value (not count) while in DB_RELEASE.
REQ-019 btn_level SHALL be 1 in HELD and DB_RELEASE and 0 in IDLE and DB_PRESS.
REQ-020 All outputs SHALL be registered.
REQ-021 Latency: if raw pressed level is first sampled at edge N and stays stable, press_pulse SHALL be high in the cycle following edge N+DEBOUNCE_CYCLES+2; release latency SHALL be identical.
REQ-022 press_pulse, release_pulse and long_press_pulse SHALL each be exactly one cycle wide, and press_pulse and release_pulse SHALL never be high together.
REQ-023 Any bounce shorter than DEBOUNCE_CYCLES clocks after synchronization SHALL produce no pulse and no btn_level change.

Reset
REQ-024 While reset_n=0: state=IDLE, db_cnt=0, hold_cnt=0, synchronizer flops = released level, and btn_level, press_pulse, release_pulse, long_press_pulse = 0.
REQ-025 Reset SHALL take effect asynchronously mid-operation; an in-progress pulse is cut and not re-issued.
REQ-026 A button held through reset deassertion SHALL be treated as a new press: it is debounced and emits press_pulse per REQ-021.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1)
REQ-027 Clean press: btn_raw 1->0 at edge N, then held -> press_pulse high exactly one cycle after edge N+6, btn_level=1 from that cycle.
REQ-028 Bounce: btn_raw low 3 cycles, high 1, low 2, high -> no pulses, and btn_level stays 0.
REQ-029 Long press: btn_raw held low 40 cycles -> one press_pulse and exactly one long_press_pulse 20 cycles after press_pulse; no second long pulse.
REQ-030 Release bounce: in HELD, btn_raw high 2 cycles then low -> no release_pulse and btn_level stays 1; a later stable high for 6+ cycles -> exactly one release_pulse and btn_level=0.
REQ-031 Reset mid-press: reset_n=0 while in HELD -> all outputs 0 immediately; btn_raw still low after release -> press_pulse 7 cycles after the first sampling edge.

Source files
------------

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up a raw, bouncing push-button pin. The pin is synchronised into the
// clk domain and normalised so that 1 means "pressed". A four-state debounce
// FSM then accepts a new level only after it has held for DEBOUNCE_CYCLES
// clocks. It reports each accepted press and release with a one-clock pulse,
// and reports a press held for LONG_PRESS_CYCLES with a single one-clock pulse.
//
// Parameters
//   DEBOUNCE_CYCLES   clocks a new level must hold before acceptance (>= 2)
//   LONG_PRESS_CYCLES clocks in HELD before a long press is reported
//                     (>= DEBOUNCE_CYCLES)
//   ACTIVE_LOW        1: btn_raw=0 means pressed, 0: btn_raw=1 means pressed
//
// Ports
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   btn_raw          in   raw button pin, asynchronous to clk, bouncing
//   btn_level        out  debounced level, 1 = pressed
//   press_pulse      out  one-clock pulse on each accepted press
//   release_pulse    out  one-clock pulse on each accepted release
//   long_press_pulse out  one-clock pulse once a press has been held long enough
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // The pin level seen when the button is not pressed.
    localparam logic RELEASED_LEVEL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_s;

    // NOTE: the synchroniser flops reset to the released pin level rather than
    // zero, so a button held through reset looks like a fresh press once reset
    // lifts and is debounced like any other press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RELEASED_LEVEL;
            r_sync2 <= RELEASED_LEVEL;
        end else begin
            // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
            // which gives a true two-stage pipeline and not a single wire.
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // ------------------------------------------------------------------
    // FSM state and counters
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [DB_W-1:0]    r_db_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_long_fired;   // long press already reported for this press

    state_t             w_state_nxt;
    logic [DB_W-1:0]    w_db_cnt_nxt;
    logic [HOLD_W-1:0]  w_hold_cnt_nxt;
    logic               w_long_fired_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_db_cnt     <= w_db_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_long_fired <= w_long_fired_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so any path
        // through the case that does not assign it holds its value and no
        // latch is inferred.
        w_state_nxt      = r_state;
        w_db_cnt_nxt     = r_db_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_long_fired_nxt = r_long_fired;

        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt  = DB_PRESS;
                    w_db_cnt_nxt = '0;
                end
            end

            DB_PRESS: begin
                if (!w_s) begin
                    // Bounce: drop back without reporting anything.
                    w_state_nxt = IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt      = HELD;
                    w_hold_cnt_nxt   = '0;
                    w_long_fired_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end

            HELD: begin
                // Hold time counts on every HELD cycle and saturates, so the
                // long-press condition stays visible until it is reported.
                if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end else begin
                    w_long_fired_nxt = 1'b1;
                end
                if (!w_s) begin
                    w_state_nxt  = DB_RELEASE;
                    w_db_cnt_nxt = '0;
                end
            end

            DB_RELEASE: begin
                // hold_cnt is left untouched here, so a rejected release bounce
                // resumes the hold time where it stopped.
                if (w_s) begin
                    w_state_nxt = HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered below)
    // ------------------------------------------------------------------
    logic w_level_nxt;
    logic w_press_nxt;
    logic w_release_nxt;
    logic w_long_nxt;

    always_comb begin
        w_press_nxt   = (r_state == DB_PRESS)   &&  w_s && (r_db_cnt == DB_LAST);
        w_release_nxt = (r_state == DB_RELEASE) && !w_s && (r_db_cnt == DB_LAST);
        w_long_nxt    = (r_state == HELD) && (r_hold_cnt == HOLD_LAST) && !r_long_fired;
        w_level_nxt   = (w_state_nxt == HELD) || (w_state_nxt == DB_RELEASE);
    end

    logic r_btn_level;
    logic r_press_pulse;
    logic r_release_pulse;
    logic r_long_press_pulse;

    // The outputs are decoded from the next state, so each output flop changes
    // on the same edge as the state transition that causes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_level        <= 1'b0;
            r_press_pulse      <= 1'b0;
            r_release_pulse    <= 1'b0;
            r_long_press_pulse <= 1'b0;
        end else begin
            r_btn_level        <= w_level_nxt;
            r_press_pulse      <= w_press_nxt;
            r_release_pulse    <= w_release_nxt;
            r_long_press_pulse <= w_long_nxt;
        end
    end

    assign btn_level        = r_btn_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_press_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20 and ACTIVE_LOW=1. A table covers a clean press and a
// clean release. Hand-written sequences cover bounce rejection, a long press,
// a release bounce and a reset in the middle of a press. Random stimulus is
// compared cycle by cycle against a reference model. The model tracks the
// debounced level and the length of the current run of samples that disagree
// with it.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;

    logic clk;
    logic reset_n;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .btn_raw          (btn_raw),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // A level is accepted once D+1 consecutive synchronised samples disagree
    // with the current debounced level. The synchroniser delays each raw
    // sample by two edges.
    bit m_p1, m_p2;            // pressed flags in flight through the synchroniser
    bit m_level;
    int m_run;                 // consecutive samples disagreeing with m_level
    int m_hold;                // cycles spent settled-pressed, saturating at L-1
    bit m_fired;
    bit m_press, m_rel, m_long;

    function automatic void model_reset();
        m_p1 = 1'b0; m_p2 = 1'b0;
        m_level = 1'b0; m_run = 0; m_hold = 0; m_fired = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    endfunction

    function automatic void model_step(input logic raw_v);
        bit s;
        bit settled_pressed;
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = ~raw_v;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        settled_pressed = m_level && (m_run == 0);
        if (settled_pressed) begin
            if (m_hold == L - 1 && !m_fired) begin
                m_long  = 1'b1;
                m_fired = 1'b1;
            end
            if (m_hold < L - 1) m_hold++;
        end
        if (s != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_press = 1'b1;
                    m_hold  = 0;
                    m_fired = 1'b0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endfunction

    // Drive btn_raw, let one rising edge pass, keep the model in step, then
    // leave 1 time unit so that outputs can be sampled away from the edge.
    task automatic tick(input logic raw_v);
        btn_raw = raw_v;
        @(posedge clk);
        if (reset_n) model_step(raw_v);
        else         model_reset();
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) tick(1'b1);
    endtask

    // ------------------------------------------------------------------
    // Directed table: clean press then clean release
    // ------------------------------------------------------------------
    typedef struct {
        logic raw;
        logic level;
        logic press;
        logic rel;
        logic lng;
    } vec_t;

    vec_t tbl[18];

    int press_cnt, rel_cnt, long_cnt, press_idx, long_idx, rel_idx;
    bit level_dropped;

    initial begin
        // Clean press at index 0 and clean release at index 10. Each pulse
        // follows its first sampling edge by D+2 edges.
        for (int i = 0; i < 18; i++) begin
            tbl[i].raw   = (i < 10) ? 1'b0 : 1'b1;
            tbl[i].press = (i == D + 2);
            tbl[i].rel   = (i == 10 + D + 2);
            tbl[i].level = (i >= D + 2) && (i < 10 + D + 2);
            tbl[i].lng   = 1'b0;
        end

        model_reset();
        reset_n = 1'b0;
        btn_raw = 1'b1;
        #2;
        check("reset_level",   btn_level,        1'b0);
        check("reset_press",   press_pulse,      1'b0);
        check("reset_release", release_pulse,    1'b0);
        check("reset_long",    long_press_pulse, 1'b0);
        tick(1'b1);
        tick(1'b1);
        #3 reset_n = 1'b1;
        settle();

        // ---- table-driven clean press / release
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].raw);
            check($sformatf("tbl%0d_level", i),   btn_level,        tbl[i].level);
            check($sformatf("tbl%0d_press", i),   press_pulse,      tbl[i].press);
            check($sformatf("tbl%0d_release", i), release_pulse,    tbl[i].rel);
            check($sformatf("tbl%0d_long", i),    long_press_pulse, tbl[i].lng);
        end
        settle();

        // ---- press bounce: low 3, high 1, low 2, then high
        press_cnt = 0; rel_cnt = 0; long_cnt = 0; level_dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick((i < 3) ? 1'b0 : (i < 4) ? 1'b1 : (i < 6) ? 1'b0 : 1'b1);
            press_cnt += press_pulse; rel_cnt += release_pulse; long_cnt += long_press_pulse;
            if (btn_level) level_dropped = 1'b1;
        end
        check("bounce_press_count",   press_cnt, 0);
        check("bounce_release_count", rel_cnt,   0);
        check("bounce_long_count",    long_cnt,  0);
        check("bounce_level_rose",    level_dropped, 1'b0);
        settle();

        // ---- long press: held low for 40 cycles
        press_cnt = 0; long_cnt = 0; press_idx = -1; long_idx = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (press_pulse)      begin press_cnt++; press_idx = i; end
            if (long_press_pulse) begin long_cnt++;  long_idx  = i; end
            check("long_press_rel_excl", press_pulse & release_pulse, 1'b0);
        end
        check("long_press_count",      press_cnt, 1);
        check("long_press_press_idx",  press_idx, D + 2);
        check("long_press_long_count", long_cnt,  1);
        check("long_press_delay",      long_idx - press_idx, L);
        check("long_press_level",      btn_level, 1'b1);
        rel_cnt = 0; rel_idx = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (release_pulse) begin rel_cnt++; rel_idx = i; end
        end
        check("long_release_count", rel_cnt, 1);
        check("long_release_idx",   rel_idx, D + 2);
        check("long_release_level", btn_level, 1'b0);
        settle();

        // ---- release bounce while held
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("relb_pressed_level", btn_level, 1'b1);
        rel_cnt = 0; level_dropped = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick((i < 2) ? 1'b1 : 1'b0);
            rel_cnt += release_pulse;
            if (!btn_level) level_dropped = 1'b1;
        end
        check("relb_bounce_release_count", rel_cnt, 0);
        check("relb_bounce_level_dropped", level_dropped, 1'b0);
        rel_cnt = 0; rel_idx = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            if (release_pulse) begin rel_cnt++; rel_idx = i; end
        end
        check("relb_release_count", rel_cnt, 1);
        check("relb_release_idx",   rel_idx, D + 2);
        check("relb_level_after",   btn_level, 1'b0);
        settle();

        // ---- reset mid-press, button still held through deassertion
        for (int i = 0; i <= D + 2; i++) tick(1'b0);
        check("rst_press_before", press_pulse, 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_level",   btn_level,        1'b0);
        check("rst_async_press",   press_pulse,      1'b0);
        check("rst_async_release", release_pulse,    1'b0);
        check("rst_async_long",    long_press_pulse, 1'b0);
        tick(1'b0);
        tick(1'b0);
        check("rst_held_press", press_pulse, 1'b0);
        check("rst_held_level", btn_level,   1'b0);
        #3 reset_n = 1'b1;
        press_cnt = 0; press_idx = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            if (press_pulse) begin press_cnt++; press_idx = i; end
        end
        check("rst_repress_count", press_cnt, 1);
        check("rst_repress_idx",   press_idx, D + 2);
        check("rst_repress_level", btn_level, 1'b1);
        settle();

        // ---- randomised runs against the reference model
        begin
            int cycles;
            logic lvl;
            int len;
            cycles = 0;
            while (cycles < 3000) begin
                lvl = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 9);
                for (int k = 0; k < len; k++) begin
                    tick(lvl);
                    check("rand_outputs",
                          {28'd0, btn_level, press_pulse, release_pulse, long_press_pulse},
                          {28'd0, m_level,   m_press,     m_rel,         m_long});
                    check("rand_press_rel_excl", press_pulse & release_pulse, 1'b0);
                    cycles++;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
